// File: rtl/sparse_nm_mac.sv
// N:M structured-sparse multiply-accumulate: decodes a weight position bitmap into
// NNZ slots, multiplies matching activation beats and accumulates into a partial sum.
module sparse_nm_mac #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 20,
  parameter int M       = 4,
  parameter int NNZ     = 2,
  parameter int SIGNED  = 0,
  parameter int SAT     = 1,
  localparam int IW     = (M > 1) ? $clog2(M) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_load,
  input  logic [NNZ*BW-1:0]  weights,
  input  logic [M-1:0]       w_index,
  input  logic [PSUM_BW-1:0] psum_in,
  input  logic               start,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [BW-1:0]      act_data,
  input  logic [IW-1:0]      act_index,
  input  logic               act_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PSUM_BW-1:0] psum_out,
  output logic [7:0]         match_cnt,
  output logic               w_err,
  output logic               busy
);
  localparam int CW = $clog2(M + 1) + 1;
  localparam int PW = 2 * BW;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

  state_t               state_r, state_s;
  logic [NNZ*BW-1:0]    weights_r;
  logic [IW-1:0]        pos_r [NNZ];
  logic [IW-1:0]        pos_s [NNZ];
  logic [NNZ-1:0]       vld_r, vld_s;
  logic [CW-1:0]        run_s;
  logic                 w_err_r, w_err_s;
  logic                 out_valid_r, act_ready_r, busy_r;
  logic                 out_valid_s, act_ready_s, busy_s;
  logic [PSUM_BW-1:0]   psum_r, sat_s;
  logic [7:0]           match_cnt_r;
  logic [PW-1:0]        prod_r, prod_s, mul_a_s, mul_b_s;
  logic                 prod_v_r;
  logic                 hit_s, accept_s, idle_s;
  logic [BW-1:0]        wsel_s;
  logic [PSUM_BW:0]     ext_s, acc_s, sum_s;

  assign idle_s   = (state_r == IDLE);
  assign accept_s = act_valid && (state_r == ACCUM);

  // Bitmap decode: k-th lowest set bit of w_index goes to slot k; extra bits are dropped
  always_comb begin
    run_s = '0;
    vld_s = '0;
    for (int k = 0; k < NNZ; k++) pos_s[k] = '0;
    for (int i = 0; i < M; i++) begin
      for (int k = 0; k < NNZ; k++) begin
        if (w_index[i] && (run_s == CW'(k))) begin
          pos_s[k] = IW'(i);
          vld_s[k] = 1'b1;
        end else begin
          pos_s[k] = pos_s[k];
        end
      end
      run_s = run_s + CW'(w_index[i]);
    end
    w_err_s = (run_s > CW'(NNZ));
  end

  // Slot match and operand extension for the product
  always_comb begin
    hit_s  = 1'b0;
    wsel_s = '0;
    for (int k = 0; k < NNZ; k++) begin
      if (vld_r[k] && (pos_r[k] == act_index)) begin
        hit_s  = 1'b1;
        wsel_s = weights_r[k*BW +: BW];
      end else begin
        hit_s  = hit_s;
      end
    end
    if (SIGNED != 0) begin
      mul_a_s = {{BW{wsel_s[BW-1]}}, wsel_s};
      mul_b_s = {{BW{act_data[BW-1]}}, act_data};
    end else begin
      mul_a_s = {{BW{1'b0}}, wsel_s};
      mul_b_s = {{BW{1'b0}}, act_data};
    end
    prod_s = mul_a_s * mul_b_s;
  end

  // Accumulate with one guard bit, then clamp or wrap
  always_comb begin
    if (SIGNED != 0) begin
      ext_s = {{(PSUM_BW+1-PW){prod_r[PW-1]}}, prod_r};
      acc_s = {psum_r[PSUM_BW-1], psum_r};
    end else begin
      ext_s = {{(PSUM_BW+1-PW){1'b0}}, prod_r};
      acc_s = {1'b0, psum_r};
    end
    sum_s = acc_s + ext_s;
    if (SAT == 0) begin
      sat_s = sum_s[PSUM_BW-1:0];
    end else if (SIGNED == 0) begin
      sat_s = sum_s[PSUM_BW] ? {PSUM_BW{1'b1}} : sum_s[PSUM_BW-1:0];
    end else if (sum_s[PSUM_BW] != sum_s[PSUM_BW-1]) begin
      sat_s = sum_s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
    end else begin
      sat_s = sum_s[PSUM_BW-1:0];
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      act_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= out_valid_s;
      act_ready_r <= act_ready_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state logic
  always_comb begin
    case (state_r)
      IDLE:    state_s = start ? ACCUM : IDLE;
      ACCUM:   state_s = (accept_s && act_last) ? FLUSH : ACCUM;
      FLUSH:   state_s = DRAIN;
      DRAIN:   state_s = out_ready ? IDLE : DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs for the upcoming state, registered above
  always_comb begin
    out_valid_s = (state_s == DRAIN);
    act_ready_s = (state_s == ACCUM);
    busy_s      = (state_s != IDLE);
  end

  // Weight store, product pipeline stage, accumulator and match counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weights_r   <= '0;
      vld_r       <= '0;
      w_err_r     <= 1'b0;
      prod_r      <= '0;
      prod_v_r    <= 1'b0;
      psum_r      <= '0;
      match_cnt_r <= 8'd0;
      for (int k = 0; k < NNZ; k++) pos_r[k] <= '0;
    end else begin
      if (idle_s && w_load) begin
        weights_r <= weights;
        vld_r     <= vld_s;
        pos_r     <= pos_s;
        w_err_r   <= w_err_s;
      end
      prod_v_r <= accept_s && hit_s;
      if (accept_s && hit_s) prod_r <= prod_s;
      if (idle_s && start) begin
        psum_r      <= psum_in;
        match_cnt_r <= 8'd0;
      end else begin
        if (prod_v_r) psum_r <= sat_s;
        if (accept_s && hit_s && (match_cnt_r != 8'hFF)) match_cnt_r <= match_cnt_r + 8'd1;
      end
    end
  end

  assign act_ready = act_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign psum_out  = psum_r;
  assign match_cnt = match_cnt_r;
  assign w_err     = w_err_r;
endmodule

// File: tb/tb_sparse_nm_mac.sv
// Directed bench: three instances (default, wrap-around, signed) share one stimulus stream.
module tb_sparse_nm_mac;
  logic clk = 1'b0;
  logic reset, w_load, start, act_valid, act_last, out_ready;
  logic [7:0]  weights;
  logic [3:0]  w_index;
  logic [19:0] psum_in;
  logic [3:0]  act_data;
  logic [1:0]  act_index;
  logic        act_ready0, act_ready1, act_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [19:0] psum0, psum1, psum2;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        err0, err1, err2;
  logic        busy0, busy1, busy2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sparse_nm_mac u0 (.clk(clk), .reset(reset), .w_load(w_load), .weights(weights), .w_index(w_index),
    .psum_in(psum_in), .start(start), .act_valid(act_valid), .act_ready(act_ready0), .act_data(act_data),
    .act_index(act_index), .act_last(act_last), .out_valid(out_valid0), .out_ready(out_ready),
    .psum_out(psum0), .match_cnt(cnt0), .w_err(err0), .busy(busy0));

  sparse_nm_mac #(.SAT(0)) u1 (.clk(clk), .reset(reset), .w_load(w_load), .weights(weights), .w_index(w_index),
    .psum_in(psum_in), .start(start), .act_valid(act_valid), .act_ready(act_ready1), .act_data(act_data),
    .act_index(act_index), .act_last(act_last), .out_valid(out_valid1), .out_ready(out_ready),
    .psum_out(psum1), .match_cnt(cnt1), .w_err(err1), .busy(busy1));

  sparse_nm_mac #(.SIGNED(1)) u2 (.clk(clk), .reset(reset), .w_load(w_load), .weights(weights), .w_index(w_index),
    .psum_in(psum_in), .start(start), .act_valid(act_valid), .act_ready(act_ready2), .act_data(act_data),
    .act_index(act_index), .act_last(act_last), .out_valid(out_valid2), .out_ready(out_ready),
    .psum_out(psum2), .match_cnt(cnt2), .w_err(err2), .busy(busy2));

  typedef struct {
    logic [3:0]       widx;
    logic [7:0]       wts;
    logic [19:0]      psum;
    int               nb;
    logic [2:0][1:0]  idx;
    logic [2:0][3:0]  act;
    logic [19:0]      e0, e1, e2;
    logic [7:0]       ecnt;
    logic             eerr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_result(input string nm);
    int lat;
    lat = 1;
    while (!out_valid0 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "/latency"}, lat, 2);
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "/idle"}, {out_valid0, busy0, busy1, busy2, act_ready0, act_ready1, act_ready2}, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit ld, input int stall, input string nm);
    w_load = ld; start = 1'b1;
    weights = v.wts; w_index = v.widx; psum_in = v.psum;
    @(posedge clk); #1;
    w_load = 1'b0; start = 1'b0;
    chk({nm, "/act_ready"}, act_ready0, 1);
    for (int b = 0; b < v.nb; b++) begin
      act_valid = 1'b1; act_index = v.idx[b]; act_data = v.act[b]; act_last = (b == v.nb - 1);
      @(posedge clk); #1;
    end
    act_valid = 1'b0; act_last = 1'b0;
    wait_result(nm);
    chk({nm, "/psum_default"}, psum0, v.e0);
    chk({nm, "/psum_wrap"}, psum1, v.e1);
    chk({nm, "/psum_signed"}, psum2, v.e2);
    chk({nm, "/match_cnt"}, {cnt0, cnt1, cnt2}, {v.ecnt, v.ecnt, v.ecnt});
    chk({nm, "/w_err"}, {err0, err1, err2}, {v.eerr, v.eerr, v.eerr});
    chk({nm, "/out_valid_all"}, {out_valid1, out_valid2}, 2'b11);
    for (int s = 0; s < stall; s++) begin
      w_load = 1'b1; w_index = 4'b1111; weights = 8'h99;
      @(posedge clk); #1;
      chk({nm, "/stall_hold"}, {out_valid0, act_ready0, psum0}, {1'b1, 1'b0, v.e0});
    end
    w_load = 1'b0;
    handshake(nm);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4'b0101, 8'h53, 20'd10, 3, {2'd2, 2'd1, 2'd0}, {4'd4, 4'd7, 4'd2}, 20'd36, 20'd36, 20'd36, 8'd2, 1'b0};
    vecs[1] = '{4'b0001, 8'h0F, 20'd1048570, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd15}, 20'd1048575, 20'd219, 20'd1048571, 8'd1, 1'b0};
    vecs[2] = '{4'b0111, 8'h32, 20'd0, 1, {2'd0, 2'd0, 2'd2}, {4'd0, 4'd0, 4'd9}, 20'd0, 20'd0, 20'd0, 8'd0, 1'b1};
    vecs[3] = '{4'b0001, 8'h0E, 20'd1, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd3}, 20'd43, 20'd43, 20'd1048571, 8'd1, 1'b0};
    vecs[4] = '{4'b1010, 8'h67, 20'd100, 3, {2'd0, 2'd1, 2'd3}, {4'd9, 4'd1, 4'd2}, 20'd119, 20'd119, 20'd119, 8'd2, 1'b0};
    vecs[5] = '{4'b0001, 8'h08, 20'h80002, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd7}, 20'h8003A, 20'h8003A, 20'h80000, 8'd1, 1'b0};
    vecs[6] = '{4'b0000, 8'h00, 20'd5, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd3}, 20'd5, 20'd5, 20'd5, 8'd0, 1'b0};
    vecs[7] = '{4'b1111, 8'h21, 20'd0, 3, {2'd3, 2'd1, 2'd0}, {4'd7, 4'd5, 4'd4}, 20'd14, 20'd14, 20'd14, 8'd2, 1'b1};

    reset = 1'b0; w_load = 1'b0; start = 1'b0; act_valid = 1'b0; act_last = 1'b0; out_ready = 1'b0;
    weights = 8'h00; w_index = 4'b0000; psum_in = 20'd0; act_data = 4'd0; act_index = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid0, act_ready0, busy0, err0, psum0, cnt0}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", {busy0, out_valid0}, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b1, 0, $sformatf("vec%0d", i));

    // DRAIN stall with ignored w_load, then an immediate back-to-back start on old weights
    v = '{4'b0101, 8'h53, 20'd10, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd2}, 20'd16, 20'd16, 20'd16, 8'd1, 1'b0};
    run_vec(v, 1'b1, 3, "stall");
    v = '{4'b0000, 8'h00, 20'd0, 1, {2'd0, 2'd0, 2'd2}, {4'd0, 4'd0, 4'd1}, 20'd5, 20'd5, 20'd5, 8'd1, 1'b0};
    run_vec(v, 1'b0, 0, "b2b_old_weights");

    // match counter saturation over 300 matching beats
    w_load = 1'b1; start = 1'b1; w_index = 4'b0001; weights = 8'h01; psum_in = 20'd0;
    @(posedge clk); #1;
    w_load = 1'b0; start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      act_valid = 1'b1; act_index = 2'd0; act_data = 4'd1; act_last = (i == 299);
      @(posedge clk); #1;
    end
    act_valid = 1'b0; act_last = 1'b0;
    wait_result("cnt_sat");
    chk("cnt_sat/match_cnt", cnt0, 255);
    chk("cnt_sat/psum", psum0, 300);
    handshake("cnt_sat");

    // asynchronous reset in the middle of an accumulation
    w_load = 1'b1; start = 1'b1; w_index = 4'b0001; weights = 8'h01; psum_in = 20'd123;
    @(posedge clk); #1;
    w_load = 1'b0; start = 1'b0;
    act_valid = 1'b1; act_index = 2'd0; act_data = 4'd3; act_last = 1'b0;
    @(posedge clk); #1;
    act_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_cnt", cnt0, 1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", {out_valid0, act_ready0, busy0, err0, psum0, cnt0}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {out_valid0, busy0}, 0);
    end
    v = '{4'b0000, 8'h00, 20'd7, 1, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd5}, 20'd7, 20'd7, 20'd7, 8'd0, 1'b0};
    run_vec(v, 1'b0, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sparse_nm_mac.md
SPARSE_NM_MAC -- requirements
Module: sparse_nm_mac

Interface
REQ-001 Parameter BW, default 4, activation/weight width in bits.
REQ-002 Parameter PSUM_BW, default 20, partial-sum width in bits; SHALL be >= 2*BW+1.
REQ-003 Parameter M, default 4, group size (dense positions per group); IW = $clog2(M).
REQ-004 Parameter NNZ, default 2, max nonzero weights per group; 1 <= NNZ <= M.
REQ-005 Parameter SIGNED, default 0; 1 = two's-complement operands and psum, 0 = unsigned.
REQ-006 Parameter SAT, default 1; 1 = saturating accumulate, 0 = wrap-around modulo 2^PSUM_BW.
REQ-007 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- w_load  in  1  capture weights/w_index.
- weights  in  NNZ*BW  packed; slot k at bits [k*BW +: BW].
- w_index  in  M  position bitmap of nonzero weights.
- psum_in  in  PSUM_BW  initial partial sum.
- start  in  1  begin an accumulation.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  block accepts a beat.
- act_data  in  BW  activation value.
- act_index  in  IW  activation position in group.
- act_last  in  1  final beat of the accumulation.
- out_valid  out  1  psum_out valid.
- out_ready  in  1  consumer accepts result.
- psum_out  out  PSUM_BW  final partial sum.
- match_cnt  out  8  matched beats in current/last accumulation.
- w_err  out  1  loaded bitmap had more than NNZ bits set.
- busy  out  1  state != IDLE.

Function
REQ-008 States: IDLE, ACCUM, FLUSH, DRAIN; exactly one state at any time.
REQ-009 w_load while in IDLE: weights registered; bitmap decoded so the k-th lowest set bit of w_index maps to slot k; slot valid flag set per mapped bit; w_err = (popcount > NNZ); set bits beyond the NNZ-th ignored.
REQ-010 w_load outside IDLE SHALL be ignored (weights, flags, w_err unchanged).
REQ-011 start in IDLE: psum_q <= psum_in, match_cnt <= 0, next state ACCUM; start outside IDLE ignored.
REQ-012 w_load and start in the same IDLE cycle: both take effect; the accumulation uses the newly loaded weights.
REQ-013 act_ready = 1 only in ACCUM; a beat is accepted when act_valid && act_ready.
REQ-014 Accepted beat whose act_index equals a valid slot's position: product weight[slot]*act_data registered in a 1-stage pipeline, added to psum_q the following cycle; match_cnt increments (saturates at 255).
REQ-015 Accepted beat with no matching slot: no product, psum_q and match_cnt unchanged (replaces gated-clock hold with an enable).
REQ-016 Product is 2*BW bits, sign- or zero-extended per SIGNED to PSUM_BW before addition.
REQ-017 SAT=1: sum clamped to max/min representable PSUM_BW value (unsigned: 0..2^PSUM_BW-1); SAT=0: wrap.
REQ-018 Accepted beat with act_last=1: next state FLUSH; FLUSH lasts exactly 1 cycle, retires the pending product, then DRAIN.
REQ-019 DRAIN: out_valid=1, psum_out = psum_q, held stable until out_valid && out_ready; then IDLE next cycle.
REQ-020 Back-to-back: start asserted in the cycle after DRAIN handshake begins a new accumulation with no bubble beyond that cycle.
REQ-021 Latency: result valid 2 cycles after the act_last beat is accepted.

Reset
REQ-022 reset=0 asynchronously forces: state IDLE, psum_q=0, product register=0, slot valid flags=0, weights=0, match_cnt=0, w_err=0, out_valid=0, act_ready=0, busy=0.
REQ-023 Reset asserted mid-ACCUM/DRAIN aborts; no out_valid after release until a new start.
REQ-024 Deassertion is sampled synchronously; first state change no earlier than the first rising edge after release.

Verification
REQ-025 Defaults, unsigned; w_index=0101, weights slot0=3, slot1=5; psum_in=10; beats (0,2),(1,7),(2,4,last) -> psum_out=36, match_cnt=2, out_valid 2 cycles after last beat.
REQ-026 SAT=1, psum_in=1048570, w_index=0001, weight=15, beat (0,15,last) -> psum_out=1048575; same with SAT=0 -> 219.
REQ-027 w_index=0111, weights 2,3 -> w_err=1; beat (2,9,last) from psum_in=0 -> psum_out=0, match_cnt=0.
REQ-028 out_ready held 0 for 3 cycles in DRAIN -> psum_out and out_valid stable; act_ready=0 throughout; w_load ignored.
REQ-029 SIGNED=1, weight=-2 (1110), beat act=3, psum_in=1 -> psum_out=-5.
REQ-030 reset=0 pulse mid-ACCUM -> all outputs 0 immediately; subsequent start with psum_in=7 and single non-matching last beat -> psum_out=7.
